// File: rtl/fp_writeback_rf.sv
// FP register file and writeback stage with a one-entry forwarded commit register.
// Define FP_CC8_EN for eight condition-code flags; otherwise a single flag is kept.
module fp_writeback_rf #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr1,
  input  logic [4:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_valid,
  input  logic [3:0]        wb_func,
  input  logic [4:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_cc_in,
  input  logic [2:0]        wb_cc_idx,
  input  logic              stall,
  output logic              cc_flag,
  input  logic [2:0]        cc_sel,
  output logic              gpr_we,
  output logic [4:0]        gpr_waddr,
  output logic [DATA_W-1:0] gpr_wdata
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    CL_NONE,
    CL_RF,
    CL_CC,
    CL_GPR
  } cls_e;

  function automatic logic in_range(input logic [4:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  cls_e              cls;
  logic              p_valid;
  cls_e              p_cls;
  logic [4:0]        p_dst;
  logic [DATA_W-1:0] p_data;
  logic              p_cc;
  logic              commit;
  logic              hit1;
  logic              hit2;

  always_comb begin
    cls = CL_NONE;
    unique case (wb_func)
      4'b0000, 4'b0001,
      4'b1000, 4'b1001: cls = CL_RF;
      4'b0010, 4'b0011,
      4'b0100, 4'b0101,
      4'b0110:          cls = CL_CC;
      4'b0111:          cls = CL_GPR;
      default:          cls = CL_NONE;
    endcase
  end

  assign commit = p_valid && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_cls   <= CL_NONE;
      p_dst   <= '0;
      p_data  <= '0;
      p_cc    <= 1'b0;
    end else if (!stall) begin
      p_valid <= wb_valid;
      p_cls   <= cls;
      p_dst   <= wb_dst;
      p_data  <= wb_data;
      p_cc    <= wb_cc_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else if (commit && p_cls == CL_RF
                 && in_range(p_dst)) begin
      regs[p_dst[AW-1:0]] <= p_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else if (commit && p_cls == CL_GPR) begin
      gpr_we    <= 1'b1;
      gpr_waddr <= p_dst;
      gpr_wdata <= p_data;
    end else begin
      gpr_we    <= 1'b0;
    end
  end

  // Only the youngest value can sit in pending, so it beats the array.
  assign hit1 = p_valid && p_cls == CL_RF
                && p_dst == rd_addr1;
  assign hit2 = p_valid && p_cls == CL_RF
                && p_dst == rd_addr2;

  assign rd_data1 = !in_range(rd_addr1) ? '0
                  : hit1 ? p_data
                  : regs[rd_addr1[AW-1:0]];
  assign rd_data2 = !in_range(rd_addr2) ? '0
                  : hit2 ? p_data
                  : regs[rd_addr2[AW-1:0]];

`ifdef FP_CC8_EN
  logic [7:0] cc;
  logic [2:0] p_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_idx <= '0;
      cc    <= '0;
    end else if (!stall) begin
      p_idx <= wb_cc_idx;
      if (p_valid && p_cls == CL_CC)
        cc[p_idx] <= p_cc;
    end
  end

  assign cc_flag = (p_valid && p_cls == CL_CC
                    && p_idx == cc_sel)
                 ? p_cc : cc[cc_sel];
`else
  logic cc;
  logic unused_cc;

  assign unused_cc = ^{cc_sel, wb_cc_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cc <= 1'b0;
    else if (commit && p_cls == CL_CC)
      cc <= p_cc;
  end

  assign cc_flag = (p_valid && p_cls == CL_CC)
                 ? p_cc : cc;
`endif

endmodule

// File: tb/tb_fp_writeback_rf.sv
// Directed bench for fp_writeback_rf: forwarding, commit, cc, MFC1, stall.
// Expected values are hand-computed per vector.
module tb_fp_writeback_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_valid;
  logic [3:0]  wb_func;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        wb_cc_in;
  logic [2:0]  wb_cc_idx;
  logic        stall;
  logic        cc_flag;
  logic [2:0]  cc_sel;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  int errs = 0;
  int nchk = 0;

  fp_writeback_rf dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_func(wb_func),
    .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_cc_in(wb_cc_in), .wb_cc_idx(wb_cc_idx),
    .stall(stall), .cc_flag(cc_flag),
    .cc_sel(cc_sel), .gpr_we(gpr_we),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [3:0] f,
                       input logic [4:0] d,
                       input logic [31:0] x,
                       input logic c,
                       input logic [2:0] i);
    wb_valid  = v;
    wb_func   = f;
    wb_dst    = d;
    wb_data   = x;
    wb_cc_in  = c;
    wb_cc_idx = i;
  endtask

  task automatic idle();
    drive(1'b0, 4'hF, 5'd0, 32'h0, 1'b0, 3'd0);
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    cc_sel   = '0;
    idle();
    tick();
    tick();

    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd1_%0d", i), rd_data1, 32'h0);
      chk($sformatf("rst_rd2_%0d", i), rd_data2, 32'h0);
    end
    chk("rst_cc", 32'(cc_flag), 32'h0);
    chk("rst_gpr_we", 32'(gpr_we), 32'h0);

    // reset with ADD f3 pending
    rst = 1'b0;
    rd_addr1 = 5'd3;
    drive(1'b1, 4'b0000, 5'd3, 32'h3F800000, 1'b0, 3'd0);
    tick();
    idle();
    chk("pend_f3_fwd", rd_data1, 32'h3F800000);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_f3", rd_data1, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_f3_after", rd_data1, 32'h0);

    // ADD f5
    rd_addr1 = 5'd5;
    drive(1'b1, 4'b0000, 5'd5, 32'h40400000, 1'b0, 3'd0);
    tick();
    idle();
    chk("add_f5_fwd", rd_data1, 32'h40400000);
    tick();
    chk("add_f5_commit", rd_data1, 32'h40400000);
    tick();
    chk("add_f5_hold", rd_data1, 32'h40400000);

    // unclassified func must not write
    drive(1'b1, 4'b1111, 5'd5, 32'hFFFFFFFF, 1'b1, 3'd0);
    tick();
    idle();
    chk("nop_f5_fwd", rd_data1, 32'h40400000);
    tick();
    chk("nop_f5", rd_data1, 32'h40400000);
    chk("nop_cc", 32'(cc_flag), 32'h0);

    // back-to-back writes to f2
    rd_addr2 = 5'd2;
    rd_addr1 = 5'd2;
    drive(1'b1, 4'b0001, 5'd2, 32'h3F800000, 1'b0, 3'd0);
    tick();
    chk("b2b_first", rd_data2, 32'h3F800000);
    drive(1'b1, 4'b1000, 5'd2, 32'h40000000, 1'b0, 3'd0);
    tick();
    idle();
    chk("b2b_second", rd_data2, 32'h40000000);
    chk("b2b_second_p1", rd_data1, 32'h40000000);
    tick();
    chk("b2b_final", rd_data2, 32'h40000000);
    tick();
    chk("b2b_final2", rd_data2, 32'h40000000);

    // f0 is writable
    rd_addr1 = 5'd0;
    drive(1'b1, 4'b1001, 5'd0, 32'hA5A5A5A5, 1'b0, 3'd0);
    tick();
    idle();
    tick();
    tick();
    chk("f0_write", rd_data1, 32'hA5A5A5A5);

    // compares
    cc_sel = 3'd0;
    drive(1'b1, 4'b0011, 5'd0, 32'h0, 1'b1, 3'd0);
    tick();
    idle();
    chk("clt_fwd", 32'(cc_flag), 32'h1);
    tick();
    chk("clt_commit", 32'(cc_flag), 32'h1);
    drive(1'b1, 4'b0010, 5'd0, 32'h0, 1'b0, 3'd0);
    tick();
    idle();
    chk("ceq_fwd", 32'(cc_flag), 32'h0);
    tick();
    chk("ceq_commit", 32'(cc_flag), 32'h0);
    chk("cmp_no_rf", rd_data1, 32'hA5A5A5A5);

    drive(1'b1, 4'b0110, 5'd0, 32'h0, 1'b1, 3'd3);
    tick();
    idle();
    tick();
    tick();
    cc_sel = 3'd3;
    #1;
    chk("cc_sel3", 32'(cc_flag), 32'h1);
    cc_sel = 3'd0;
    #1;
`ifdef FP_CC8_EN
    chk("cc_sel0", 32'(cc_flag), 32'h0);
`else
    chk("cc_sel0", 32'(cc_flag), 32'h1);
`endif

    // MFC1
    rd_addr1 = 5'd9;
    drive(1'b1, 4'b0111, 5'd9, 32'hC0A00000, 1'b0, 3'd0);
    tick();
    idle();
    chk("mfc1_cap_we", 32'(gpr_we), 32'h0);
    chk("mfc1_no_fwd", rd_data1, 32'h0);
    tick();
    chk("mfc1_we", 32'(gpr_we), 32'h1);
    chk("mfc1_waddr", 32'(gpr_waddr), 32'd9);
    chk("mfc1_wdata", gpr_wdata, 32'hC0A00000);
    tick();
    chk("mfc1_we_off", 32'(gpr_we), 32'h0);
    chk("mfc1_f9", rd_data1, 32'h0);

    // stall with MOV.S f7 pending
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd8;
    drive(1'b1, 4'b1001, 5'd7, 32'h12345678, 1'b0, 3'd0);
    tick();
    stall = 1'b1;
    drive(1'b1, 4'b0000, 5'd7, 32'hDEADBEEF, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1)
        drive(1'b1, 4'b0111, 5'd8, 32'h55555555, 1'b0, 3'd0);
      tick();
      chk($sformatf("stall_fwd_%0d", i), rd_data1, 32'h12345678);
      chk($sformatf("stall_gpr_%0d", i), 32'(gpr_we), 32'h0);
    end
    stall = 1'b0;
    idle();
    tick();
    chk("stall_commit", rd_data1, 32'h12345678);
    chk("stall_drop_gpr", 32'(gpr_we), 32'h0);
    tick();
    chk("stall_final", rd_data1, 32'h12345678);
    chk("stall_f8", rd_data2, 32'h0);
    chk("stall_gpr_end", 32'(gpr_we), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
